uart_receiver: RTL and testbench

- Receive stage fed by the baud rate generator.
- Consumes the 16x-oversampling tick (Rx_sample_ENABLE) and the serial line RxD.
- Recovers 8N1+parity frames: 1 start bit, DATA_BITS data bits LSB-first, optional even parity bit, 1 stop bit.
- Presents the received byte with valid and error flags to the downstream decode/7-segment logic.

---
 rtl/uart_receiver_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_receiver.sv | 139 +++++++++++++
 tb/tb_uart_receiver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: FSM state encodings and default frame parameters
// used by both the receiver and the transmitter.
package uart_receiver_pkg;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam bit          DEF_PARITY_EN  = 1'b1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic Clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled start/data/parity/stop recovery with
// registered byte, one-cycle valid pulse and per-frame parity/framing flags.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit          PARITY_EN  = DEF_PARITY_EN
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 Rx_sample_ENABLE,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    logic                 rxd_s;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d, perr_d, ferr_d;
    logic                 perr_c, ferr_c;
    logic                 half_c, full_c;

    uart_rx_sync u_sync (
        .Clk   (Clk),
        .reset (reset),
        .d     (RxD),
        .q     (rxd_s)
    );

    assign half_c = (tick_q == TW'(OVERSAMPLE/2 - 1));
    assign full_c = (tick_q == TW'(OVERSAMPLE - 1));
    assign perr_c = PARITY_EN & ((^shift_q) ^ par_bit_q);
    assign ferr_c = ~rxd_s;

    // Next-state and frame-result logic; everything advances only on sample ticks.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = Rx_DATA;
        perr_d    = Rx_PERROR;
        ferr_d    = Rx_FERROR;
        valid_d   = 1'b0;

        if (Rx_sample_ENABLE) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (half_c) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (full_c) begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BW'(DATA_BITS - 1))
                            state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (full_c) begin
                        par_bit_d = rxd_s;
                        tick_d    = '0;
                        state_d   = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (full_c) begin
                        data_d  = shift_q;
                        perr_d  = perr_c;
                        ferr_d  = ferr_c;
                        valid_d = ~perr_c & ~ferr_c;
                        tick_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            Rx_DATA   <= data_d;
            Rx_VALID  <= valid_d;
            Rx_PERROR <= perr_d;
            Rx_FERROR <= ferr_d;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a driver serialises frames and queues the
// expected result; an independent monitor pops and compares on every output event.
module tb_uart_receiver;

    localparam int TICK_DIV = 27;
    localparam int OS       = 16;
    localparam int BIT_CLKS = TICK_DIV * OS;

    logic       Clk;
    logic       reset;
    logic       Rx_sample_ENABLE;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       valid;
    } exp_t;

    exp_t   exp_q[$];
    longint vtimes[$];
    exp_t   last_exp;
    int     checks;
    int     passed;
    bit     mon_en;

    uart_receiver dut (
        .Clk              (Clk),
        .reset            (reset),
        .Rx_sample_ENABLE (Rx_sample_ENABLE),
        .RxD              (RxD),
        .Rx_DATA          (Rx_DATA),
        .Rx_VALID         (Rx_VALID),
        .Rx_PERROR        (Rx_PERROR),
        .Rx_FERROR        (Rx_FERROR)
    );

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    // Oversampling tick: one Clk wide, every TICK_DIV clocks
    initial begin
        Rx_sample_ENABLE = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge Clk);
            Rx_sample_ENABLE = 1'b1;
            @(negedge Clk);
            Rx_sample_ENABLE = 1'b0;
        end
    end

    // Reference model: even parity means the total count of ones (data + parity) is even
    function automatic exp_t model(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        int   ones;
        ones    = $countones(d) + int'(par);
        e.data  = d;
        e.perr  = (ones % 2) != 0;
        e.ferr  = !stop;
        e.valid = !e.perr && !e.ferr;
        return e;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    task automatic drive_bits(input logic b, input int clks);
        RxD = b;
        repeat (clks) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int idle_bits);
        exp_t e;
        e = model(d, par, stop);
        exp_q.push_back(e);
        last_exp = e;
        drive_bits(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bits(d[i], BIT_CLKS);
        drive_bits(par, BIT_CLKS);
        drive_bits(stop, BIT_CLKS);
        drive_bits(1'b1, idle_bits * BIT_CLKS);
    endtask

    // Monitor: any valid pulse or change of the held outputs is one frame result
    initial begin
        logic [9:0] prev, cur;
        logic       prev_valid;
        longint     cyc;
        exp_t       e, got;
        prev       = '0;
        prev_valid = 1'b0;
        cyc        = 0;
        wait (mon_en);
        forever begin
            @(negedge Clk);
            cyc++;
            cur = {Rx_DATA, Rx_PERROR, Rx_FERROR};
            if (Rx_VALID && prev_valid) begin
                checks++;
                $display("FAIL valid_width got=2+ cycles exp=1 cycle at cyc=%0d", cyc);
            end
            if (Rx_VALID) vtimes.push_back(cyc);
            if (Rx_VALID || cur != prev) begin
                got = {cur, Rx_VALID};
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_output got=%h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got === e) passed++;
                    else $display("FAIL frame_result got data=%h perr=%b ferr=%b valid=%b exp data=%h perr=%b ferr=%b valid=%b",
                                  got.data, got.perr, got.ferr, got.valid,
                                  e.data, e.perr, e.ferr, e.valid);
                end
            end
            prev       = cur;
            prev_valid = Rx_VALID;
        end
    end

    initial begin
        int         n0;
        int         waited;
        logic [7:0] d;
        logic       par, stop, par_ok;
        int         idle;
        exp_t       e;

        checks   = 0;
        passed   = 0;
        mon_en   = 1'b0;
        last_exp = '0;
        RxD      = 1'b1;
        reset    = 1'b0;
        repeat (5) @(negedge Clk);
        check("reset_data",  int'(Rx_DATA),   0);
        check("reset_valid", int'(Rx_VALID),  0);
        check("reset_perr",  int'(Rx_PERROR), 0);
        check("reset_ferr",  int'(Rx_FERROR), 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        drive_bits(1'b1, BIT_CLKS);

        send_frame(8'hA5, 1'b0, 1'b1, 1);
        send_frame(8'h3C, 1'b1, 1'b1, 1);
        send_frame(8'h81, 1'b0, 1'b0, 1);
        send_frame(8'h7E, 1'b0, 1'b1, 1);

        // Short low glitch must be rejected silently
        drive_bits(1'b0, 4 * TICK_DIV);
        drive_bits(1'b1, 2 * BIT_CLKS);

        // Reset in the middle of data bit 3 of 0x12
        drive_bits(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bits(8'h12 >> i & 8'h01, BIT_CLKS);
        drive_bits(1'b0, BIT_CLKS / 2);
        RxD = 1'b1;
        exp_q.push_back('0);
        last_exp = '0;
        reset = 1'b0;
        @(negedge Clk);
        reset = 1'b1;
        check("midreset_data",  int'(Rx_DATA),   0);
        check("midreset_valid", int'(Rx_VALID),  0);
        check("midreset_perr",  int'(Rx_PERROR), 0);
        check("midreset_ferr",  int'(Rx_FERROR), 0);
        drive_bits(1'b1, 2 * BIT_CLKS);
        send_frame(8'h55, 1'b0, 1'b1, 1);

        // Back-to-back frames with no idle gap
        n0 = vtimes.size();
        send_frame(8'h00, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 2);
        check("b2b_pulses", vtimes.size() - n0, 2);
        if (vtimes.size() >= n0 + 2)
            check("b2b_spacing", int'(vtimes[n0+1] - vtimes[n0]), 11 * BIT_CLKS);

        for (int k = 0; k < 5; k++) begin
            d      = 8'($urandom);
            par_ok = ($urandom_range(0, 3) != 0);
            stop   = ($urandom_range(0, 4) != 0);
            par    = (^d) ^ !par_ok;
            e      = model(d, par, stop);
            if (!e.valid && e[10:1] == last_exp[10:1]) begin
                d   = d ^ 8'h01;
                par = (^d) ^ !par_ok;
            end
            idle = stop ? int'($urandom_range(0, 1)) : 1;
            send_frame(d, par, stop, idle);
        end

        drive_bits(1'b1, BIT_CLKS);
        waited = 0;
        while (exp_q.size() != 0 && waited < 4 * BIT_CLKS) begin
            @(negedge Clk);
            waited++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
